ram_bist_master: RTL

- Avalon-MM fixed-latency master that drives the 32-bit single-port on-chip RAM (2048 words, 1-cycle read latency, no waitrequest).
- Fills an address window with a deterministic pattern, reads it back, or both, and reports pass/fail, error count and first failing address.
- Sits beside the CPU on the RAM's second slave port; used for power-on memory test and RAM initialisation in the alarm-clock SoC.

---
 rtl/ram_bist_master_pkg.sv | 21 ++
 rtl/ram_bist_checker.sv | 66 ++++++
 rtl/ram_bist_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_master_pkg.sv
// Shared types and defaults for the on-chip RAM BIST master.
package ram_bist_master_pkg;

   localparam int unsigned DEF_ADDR_W = 11;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_DEPTH  = 2048;

   localparam logic [1:0] MODE_NONE  = 2'd0;
   localparam logic [1:0] MODE_FILL  = 2'd1;
   localparam logic [1:0] MODE_CHECK = 2'd2;
   localparam logic [1:0] MODE_BOTH  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_CHECK,
      ST_DRAIN,
      ST_FINISH
   } state_e;

endpackage

// File: rtl/ram_bist_checker.sv
// One-stage expected-data pipeline and mismatch accumulator for BIST reads.
module ram_bist_checker
   import ram_bist_master_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              flush,
   input  logic              rd_issue,
   input  logic [ADDR_W-1:0] exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [DATA_W-1:0] readdata,
   output logic              mismatch_c,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] exp_q, exp_d;
   logic [ADDR_W-1:0] eaddr_q, eaddr_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] first_q, first_d;

   // A flushed (aborted) return is never counted.
   assign mismatch_c     = valid_q && !flush && (readdata != exp_q);
   assign err_count      = err_q;
   assign first_err_addr = first_q;

   always_comb begin
      valid_d = rd_issue;
      exp_d   = exp_data;
      eaddr_d = exp_addr;
      err_d   = err_q;
      first_d = first_q;
      if (clear) begin
         err_d   = '0;
         first_d = '0;
      end else if (mismatch_c) begin
         if (err_q != CNT_W'(DEPTH)) err_d = err_q + CNT_W'(1);
         if (err_q == '0)            first_d = eaddr_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         exp_q   <= '0;
         eaddr_q <= '0;
         err_q   <= '0;
         first_q <= '0;
      end else begin
         valid_q <= valid_d;
         exp_q   <= exp_d;
         eaddr_q <= eaddr_d;
         err_q   <= err_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/ram_bist_master.sv
// Avalon-MM fixed-latency BIST master: fills and/or checks a RAM window with seed+i.
module ram_bist_master
   import ram_bist_master_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          mode,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     word_count,
   input  logic [DATA_W-1:0]   seed,
   output logic [ADDR_W-1:0]   address,
   output logic [DATA_W/8-1:0] byteenable,
   output logic                chipselect,
   output logic                write,
   output logic [DATA_W-1:0]   writedata,
   output logic                clken,
   input  logic [DATA_W-1:0]   readdata,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ADDR_W:0]     err_count,
   output logic [ADDR_W-1:0]   first_err_addr
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = ADDR_W + 1;

   state_e            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
   logic [CNT_W-1:0]  count_q, count_d, rem_q, rem_d;
   logic [DATA_W-1:0] seed_q, seed_d, wdata_q, wdata_d;
   logic              cs_q, cs_d, wr_q, wr_d;
   logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, clken_q;
   logic              abort_c, clear_c, mismatch_c, err_zero_c;
   logic [ADDR_W-1:0] addr_inc_c;

   assign abort_c    = abort && (state_q == ST_FILL || state_q == ST_CHECK || state_q == ST_DRAIN);
   assign addr_inc_c = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
   assign err_zero_c = (err_count == '0) && !mismatch_c;

   // Abort drops the bus in the same cycle, so these bypass the output flops.
   assign chipselect = cs_q & ~abort_c;
   assign write      = wr_q & ~abort_c;
   assign byteenable = {BE_W{chipselect}};
   assign address    = addr_q;
   assign writedata  = wdata_q;
   assign clken      = clken_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;

   ram_bist_checker #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_checker (
      .clk            (clk),
      .reset          (reset),
      .clear          (clear_c),
      .flush          (abort_c),
      .rd_issue       (cs_q & ~wr_q & ~abort_c),
      .exp_addr       (addr_q),
      .exp_data       (wdata_q),
      .readdata       (readdata),
      .mismatch_c     (mismatch_c),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      base_d  = base_q;
      count_d = count_q;
      seed_d  = seed_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cs_d    = 1'b0;
      wr_d    = 1'b0;
      pass_d  = pass_q;
      clear_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               clear_c = 1'b1;
               if (mode != MODE_NONE && word_count != '0) begin
                  pass_d  = 1'b0;
                  mode_d  = mode;
                  base_d  = base_addr;
                  count_d = word_count;
                  seed_d  = seed;
                  rem_d   = word_count;
                  addr_d  = base_addr;
                  wdata_d = seed;
                  cs_d    = 1'b1;
                  wr_d    = (mode != MODE_CHECK);
                  state_d = (mode == MODE_CHECK) ? ST_CHECK : ST_FILL;
               end else begin
                  pass_d  = 1'b1;
                  state_d = ST_FINISH;
               end
            end
         end
         ST_FILL, ST_CHECK: begin
            if (abort_c) begin
               pass_d  = 1'b0;
               state_d = ST_FINISH;
            end else if (rem_q != CNT_W'(1)) begin
               rem_d   = rem_q - CNT_W'(1);
               addr_d  = addr_inc_c;
               wdata_d = wdata_q + DATA_W'(1);
               cs_d    = 1'b1;
               wr_d    = wr_q;
            end else if (state_q == ST_CHECK) begin
               state_d = ST_DRAIN;
            end else if (mode_q == MODE_BOTH) begin
               rem_d   = count_q;
               addr_d  = base_q;
               wdata_d = seed_q;
               cs_d    = 1'b1;
               state_d = ST_CHECK;
            end else begin
               pass_d  = err_zero_c;
               state_d = ST_FINISH;
            end
         end
         ST_DRAIN: begin
            pass_d  = abort_c ? 1'b0 : err_zero_c;
            state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_FINISH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_NONE;
         base_q  <= '0;
         count_q <= '0;
         seed_q  <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cs_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         clken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         base_q  <= base_d;
         count_q <= count_d;
         seed_q  <= seed_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cs_q    <= cs_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         clken_q <= 1'b1;
      end
   end

endmodule
